// File: rtl/kanji_rom_reader.sv
// kanji_rom_reader: fetches kanji font bytes from shared external memory for the bus read-data mux.
// Define KANJI_ROM_READER_CACHE_EN to add a single-entry cache of the last memory-fetched byte.
module kanji_rom_reader #(
  parameter logic [21:0] BASE_ADDRESS = 22'h000000,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [17:0] kanji_rom_address,
  input  logic        kanji_rom_address_en,
  output logic [21:0] mem_address,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rdata_en,
  output logic [7:0]  bus_rdata,
  output logic        bus_rdata_en,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned AW = 22;
  localparam int unsigned KW = 18;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [AW-1:0]      r_mem_address;
  logic [AW-1:0]      w_mem_address_nxt;
  logic               r_mem_valid;
  logic [DW-1:0]      r_bus_rdata;
  logic               r_bus_rdata_en;
  logic               r_busy;
  logic               r_overrun;
  logic               w_overrun_nxt;
  logic [DW-1:0]      r_data;
  logic [DW-1:0]      w_data_nxt;
  logic               r_pend_vld;
  logic               w_pend_vld_nxt;
  logic [KW-1:0]      r_pend_addr;
  logic [KW-1:0]      w_pend_addr_nxt;
  logic [TIMEOUT-1:0] r_wdog;
  logic [TIMEOUT-1:0] w_wdog_nxt;
  logic [TIMEOUT-1:0] w_wdog_inc;
  logic               w_launch;
  logic [KW-1:0]      w_launch_addr;

`ifdef KANJI_ROM_READER_CACHE_EN
  logic               r_cache_vld;
  logic [KW-1:0]      r_cache_addr;
  logic [DW-1:0]      r_cache_data;
  logic [KW-1:0]      r_cur_addr;
  logic               w_hit;
  logic               w_fill;

  assign w_hit  = r_cache_vld && (r_cache_addr == kanji_rom_address);
  // Only real memory data reaches DONE from REQ/WAIT with mem_rdata_en; timeouts never fill.
  assign w_fill = mem_rdata_en && (w_state_nxt == ST_DONE) && (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cache_vld  <= 1'b0;
      r_cache_addr <= '0;
      r_cache_data <= '0;
      r_cur_addr   <= '0;
    end else begin
      if (w_launch) begin
        r_cur_addr <= w_launch_addr;
      end
      if (w_fill) begin
        r_cache_vld  <= 1'b1;
        r_cache_addr <= r_cur_addr;
        r_cache_data <= mem_rdata;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, pending slot, watchdog and launch decision
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_address_nxt = r_mem_address;
    w_pend_vld_nxt    = r_pend_vld;
    w_pend_addr_nxt   = r_pend_addr;
    w_overrun_nxt     = r_overrun;
    w_data_nxt        = r_data;
    w_wdog_inc        = r_wdog + TIMEOUT'(1);
    w_wdog_nxt        = r_wdog;
    w_launch          = 1'b0;
    w_launch_addr     = r_pend_addr;

    case (r_state)
      ST_IDLE: begin
        if (r_pend_vld) begin
          w_launch       = 1'b1;
          w_pend_vld_nxt = kanji_rom_address_en;
          if (kanji_rom_address_en) begin
            w_pend_addr_nxt = kanji_rom_address;
          end
        end else if (kanji_rom_address_en) begin
`ifdef KANJI_ROM_READER_CACHE_EN
          if (w_hit) begin
            w_state_nxt = ST_DONE;
            w_data_nxt  = r_cache_data;
          end else begin
            w_launch      = 1'b1;
            w_launch_addr = kanji_rom_address;
          end
`else
          w_launch      = 1'b1;
          w_launch_addr = kanji_rom_address;
`endif
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          if (mem_rdata_en) begin
            w_state_nxt = ST_DONE;
            w_data_nxt  = mem_rdata;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_wdog_nxt = w_wdog_inc;
        if (mem_rdata_en) begin
          w_state_nxt = ST_DONE;
          w_data_nxt  = mem_rdata;
        end else if (&w_wdog_inc) begin
          w_state_nxt = ST_DONE;
          w_data_nxt  = DW'(8'hFF);
        end
      end
      ST_DONE: begin
        w_wdog_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Strobes arriving mid-transaction park in the slot; newest address wins
    if (kanji_rom_address_en && (r_state != ST_IDLE)) begin
      w_overrun_nxt   = r_overrun | r_pend_vld;
      w_pend_vld_nxt  = 1'b1;
      w_pend_addr_nxt = kanji_rom_address;
    end

    if (w_launch) begin
      w_state_nxt       = ST_REQ;
      w_mem_address_nxt = BASE_ADDRESS + AW'(w_launch_addr);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_mem_address  <= '0;
      r_mem_valid    <= 1'b0;
      r_bus_rdata    <= DW'(8'hFF);
      r_bus_rdata_en <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_data         <= DW'(8'hFF);
      r_pend_vld     <= 1'b0;
      r_pend_addr    <= '0;
      r_wdog         <= '0;
    end else begin
      r_mem_address  <= w_mem_address_nxt;
      r_mem_valid    <= (w_state_nxt == ST_REQ);
      r_bus_rdata_en <= (r_state == ST_DONE);
      r_busy         <= (w_state_nxt != ST_IDLE) | w_pend_vld_nxt;
      r_overrun      <= w_overrun_nxt;
      r_data         <= w_data_nxt;
      r_pend_vld     <= w_pend_vld_nxt;
      r_pend_addr    <= w_pend_addr_nxt;
      r_wdog         <= w_wdog_nxt;
      if (r_state == ST_DONE) begin
        r_bus_rdata <= r_data;
      end
    end
  end

  assign mem_address  = r_mem_address;
  assign mem_valid    = r_mem_valid;
  assign bus_rdata    = r_bus_rdata;
  assign bus_rdata_en = r_bus_rdata_en;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_kanji_rom_reader.sv
// tb_kanji_rom_reader: directed and randomized checks of kanji_rom_reader against a transaction-level model.
// Expectations follow KANJI_ROM_READER_CACHE_EN when the bench is built with it defined.
module tb_kanji_rom_reader;

  localparam logic [21:0] BASE = 22'h100000;
  localparam int unsigned TMO  = 8;
`ifdef KANJI_ROM_READER_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk;
  logic        n_reset;
  logic [17:0] kanji_rom_address;
  logic        kanji_rom_address_en;
  logic [21:0] mem_address;
  logic        mem_valid;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        mem_rdata_en;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;
  logic        busy;
  logic        overrun;

  kanji_rom_reader #(.BASE_ADDRESS(BASE), .TIMEOUT(TMO)) dut (
    .clk                  (clk),
    .n_reset              (n_reset),
    .kanji_rom_address    (kanji_rom_address),
    .kanji_rom_address_en (kanji_rom_address_en),
    .mem_address          (mem_address),
    .mem_valid            (mem_valid),
    .mem_ready            (mem_ready),
    .mem_rdata            (mem_rdata),
    .mem_rdata_en         (mem_rdata_en),
    .bus_rdata            (bus_rdata),
    .bus_rdata_en         (bus_rdata_en),
    .busy                 (busy),
    .overrun              (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_req    = 0;
  int n_rsp    = 0;
  int strobe_cyc   = 0;
  int last_rsp_cyc = 0;
  int inject_cnt   = 0;
  int inject_done  = 0;

  // memory behaviour knobs
  bit         rand_mode = 1'b0;
  bit         drop_data = 1'b0;
  bit         fixed_en  = 1'b0;
  logic [7:0] fixed_data = 8'h00;
  int         rdy_dly   = 0;
  int         data_dly  = 1;

  // transaction-level model
  logic [7:0]  exp_q[$];
  logic [21:0] addr_q[$];
  bit          m_overrun = 1'b0;
  bit          cache_v   = 1'b0;
  logic [17:0] cache_a   = '0;
  logic [7:0]  cache_d   = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  function automatic logic [21:0] maddr(input logic [17:0] k);
    longint unsigned s;
    s = longint'(BASE) + longint'(k);
    return 22'(s % (64'd1 << 22));
  endfunction

  function automatic logic [7:0] exp_byte(input logic [17:0] k);
    return fixed_en ? fixed_data : mem_byte(maddr(k));
  endfunction

  task automatic expect_fetch(input logic [17:0] k, input logic [7:0] d);
    addr_q.push_back(maddr(k));
    exp_q.push_back(d);
    cache_v = 1'b1;
    cache_a = k;
    cache_d = d;
  endtask

  task automatic expect_access(input logic [17:0] k);
    if (CACHE_ON && cache_v && (cache_a == k)) exp_q.push_back(cache_d);
    else expect_fetch(k, exp_byte(k));
  endtask

  task automatic strobe(input logic [17:0] k);
    kanji_rom_address    = k;
    kanji_rom_address_en = 1'b1;
    strobe_cyc           = cyc;
    @(negedge clk);
    kanji_rom_address_en = 1'b0;
  endtask

  // first strobe is served, later ones share one slot where the newest wins
  task automatic burst(input int k, input logic [17:0] a0, input logic [17:0] a1,
                       input logic [17:0] a2);
    expect_access(a0);
    if (k == 2) expect_fetch(a1, exp_byte(a1));
    if (k == 3) begin
      expect_fetch(a2, exp_byte(a2));
      m_overrun = 1'b1;
    end
    strobe(a0);
    if (k >= 2) strobe(a1);
    if (k >= 3) strobe(a2);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size() + addr_q.size()), 32'd0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // response monitor
  initial forever begin
    @(negedge clk);
    if (bus_rdata_en === 1'b1) begin
      n_rsp++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else chk("bus_rdata", 32'(bus_rdata), 32'(exp_q.pop_front()));
    end
  end

  // external memory responder
  initial begin : responder
    int rdy;
    int dd;
    logic [21:0] a;
    mem_ready    = 1'b0;
    mem_rdata_en = 1'b0;
    mem_rdata    = 8'h00;
    forever begin
      @(negedge clk);
      if (inject_cnt != inject_done) begin
        mem_rdata    = 8'h77;
        mem_rdata_en = 1'b1;
        @(negedge clk);
        mem_rdata_en = 1'b0;
        inject_done++;
      end else if (mem_valid === 1'b1) begin
        n_req++;
        a = mem_address;
        if (addr_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else chk("mem_address", 32'(a), 32'(addr_q.pop_front()));
        rdy = rand_mode ? int'($urandom_range(0, 3)) : rdy_dly;
        dd  = rand_mode ? int'($urandom_range(0, 4)) : data_dly;
        for (int i = 0; i < rdy; i++) begin
          @(negedge clk);
          chk("valid_held", 32'(mem_valid), 32'd1);
          chk("addr_stable", 32'(mem_address), 32'(a));
        end
        mem_ready = 1'b1;
        if (dd == 0 && !drop_data) begin
          mem_rdata    = fixed_en ? fixed_data : mem_byte(a);
          mem_rdata_en = 1'b1;
        end
        @(negedge clk);
        mem_ready    = 1'b0;
        mem_rdata_en = 1'b0;
        if (dd > 0 && !drop_data) begin
          for (int i = 1; i < dd; i++) @(negedge clk);
          mem_rdata    = fixed_en ? fixed_data : mem_byte(a);
          mem_rdata_en = 1'b1;
          @(negedge clk);
          mem_rdata_en = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin : main
    int base_req;
    int base_rsp;
    int k;
    logic [17:0] a0;
    logic [17:0] a1;
    logic [17:0] a2;

    n_reset              = 1'b0;
    kanji_rom_address    = '0;
    kanji_rom_address_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_bus_rdata", 32'(bus_rdata), 32'hFF);
    chk("rst_bus_rdata_en", 32'(bus_rdata_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    n_reset = 1'b1;
    @(negedge clk);

    // zero-wait fetch
    fixed_en = 1'b1; fixed_data = 8'h3C; rdy_dly = 0; data_dly = 1;
    expect_access(18'h08E40);
    strobe(18'h08E40);
    chk("t1_mem_valid", 32'(mem_valid), 32'd1);
    chk("t1_mem_address", 32'(mem_address), 32'h108E40);
    drain(50);
    chk("t1_latency", 32'(last_rsp_cyc - strobe_cyc), 32'd4);
    chk("t1_bus_rdata", 32'(bus_rdata), 32'h3C);

    // JIS2 address, ready delayed 3 cycles
    fixed_data = 8'hA5; rdy_dly = 3;
    base_rsp = n_rsp;
    expect_access(18'h2D680);
    strobe(18'h2D680);
    drain(50);
    chk("t2_latency", 32'(last_rsp_cyc - strobe_cyc), 32'd7);
    chk("t2_rsp_count", 32'(n_rsp - base_rsp), 32'd1);
    chk("t2_bus_rdata", 32'(bus_rdata), 32'hA5);

    // three back-to-back strobes against slow memory
    fixed_en = 1'b0; rdy_dly = 2; data_dly = 3;
    base_rsp = n_rsp;
    burst(3, 18'h01234, 18'h05678, 18'h3FFFF);
    chk("t3_busy_during", 32'(busy), 32'd1);
    chk("t3_overrun", 32'(overrun), 32'd1);
    drain(100);
    chk("t3_busy_after", 32'(busy), 32'd0);
    chk("t3_rsp_count", 32'(n_rsp - base_rsp), 32'd2);

    // reset while waiting for data
    drop_data = 1'b1; rdy_dly = 0;
    addr_q.push_back(maddr(18'h00ABC));
    strobe(18'h00ABC);
    repeat (3) @(negedge clk);
    chk("t4_busy_pre", 32'(busy), 32'd1);
    #1 n_reset = 1'b0;
    #1;
    chk("t4_mem_valid", 32'(mem_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_overrun", 32'(overrun), 32'd0);
    chk("t4_bus_rdata", 32'(bus_rdata), 32'hFF);
    exp_q.delete();
    addr_q.delete();
    m_overrun = 1'b0;
    cache_v   = 1'b0;
    @(negedge clk);
    n_reset   = 1'b1;
    drop_data = 1'b0;
    @(negedge clk);

    // normal fetch after reset, then repeat of the same address
    fixed_en = 1'b1; fixed_data = 8'h3C; rdy_dly = 0; data_dly = 1;
    expect_access(18'h08E40);
    strobe(18'h08E40);
    drain(50);
    chk("t5_latency", 32'(last_rsp_cyc - strobe_cyc), 32'd4);
    chk("t5_bus_rdata", 32'(bus_rdata), 32'h3C);

    base_req = n_req;
    expect_access(18'h08E40);
    strobe(18'h08E40);
    drain(50);
    chk("t6_mem_reads", 32'(n_req - base_req), CACHE_ON ? 32'd0 : 32'd1);
    chk("t6_latency", 32'(last_rsp_cyc - strobe_cyc), CACHE_ON ? 32'd2 : 32'd4);
    chk("t6_bus_rdata", 32'(bus_rdata), 32'h3C);

    // response timeout: REQ, 2^TMO-1 WAIT cycles, DONE, then the pulse
    fixed_en = 1'b0; drop_data = 1'b1;
    addr_q.push_back(maddr(18'h00100));
    exp_q.push_back(8'hFF);
    strobe(18'h00100);
    drain(400);
    chk("t7_latency", 32'(last_rsp_cyc - strobe_cyc), 32'((1 << TMO) + 2));
    chk("t7_bus_rdata", 32'(bus_rdata), 32'hFF);
    base_rsp = n_rsp;
    inject_cnt++;
    repeat (10) @(negedge clk);
    chk("t7_late_ignored", 32'(n_rsp - base_rsp), 32'd0);
    chk("t7_bus_rdata_kept", 32'(bus_rdata), 32'hFF);
    chk("t7_busy", 32'(busy), 32'd0);

    // a timed-out address is fetched again from memory
    drop_data = 1'b0;
    base_req = n_req;
    expect_access(18'h00100);
    strobe(18'h00100);
    drain(50);
    chk("t8_mem_reads", 32'(n_req - base_req), 32'd1);

    // randomized bursts with random memory timing
    rand_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(1, 3));
      do a0 = 18'($urandom); while (cache_v && a0 == cache_a);
      a1 = 18'($urandom);
      a2 = 18'($urandom);
      burst(k, a0, a1, a2);
      drain(200);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      chk("rand_busy_idle", 32'(busy), 32'd0);
    end
    chk("final_overrun", 32'(overrun), 32'(m_overrun));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kanji_rom_reader.md
Name: kanji_rom_reader

Overview:
- Downstream consumer of kanji_rom_inst.
- Takes each kanji_rom_address / kanji_rom_address_en strobe, fetches the addressed font byte from the shared external memory (flash/SDRAM arbiter port), and returns it to the bus read-data mux with a one-cycle valid pulse.
- Provides a one-deep pending slot, a response timeout and an overrun flag, so back-to-back D9h/DBh reads are never silently lost.

Parameters:
- BASE_ADDRESS, 22'h000000: base of the 256 KiB kanji font image in external memory; mem_address = BASE_ADDRESS + {4'd0, kanji_rom_address}.
- TIMEOUT, 8: width of the response watchdog counter; timeout fires after 2^TIMEOUT - 1 cycles in WAIT.

Ports:
- clk  in  1  system clock (85.909 MHz)
- n_reset  in  1  asynchronous, active-low reset
- kanji_rom_address  in  18  font byte address from kanji_rom_inst; bit17 = 1 means JIS2
- kanji_rom_address_en  in  1  one-clock strobe: address valid, fetch requested
- mem_address  out  22  external memory byte address
- mem_valid  out  1  read request; held until mem_ready
- mem_ready  in  1  request accepted by arbiter
- mem_rdata  in  8  read data
- mem_rdata_en  in  1  one-clock strobe: mem_rdata valid
- bus_rdata  out  8  fetched font byte, held until the next response
- bus_rdata_en  out  1  one-clock strobe: bus_rdata updated
- busy  out  1  high while a fetch is outstanding or pending
- overrun  out  1  sticky; a strobe arrived with the pending slot full; cleared only by reset

Behaviour:
- Reset values (n_reset low, asynchronous): state = IDLE; mem_address = 0; mem_valid = 0; bus_rdata = 8'hFF; bus_rdata_en = 0; busy = 0; overrun = 0; pending slot empty; watchdog = 0.
- State IDLE:
  - On strobe (or pending slot occupied), register mem_address = BASE_ADDRESS + address.
  - Assert mem_valid next cycle and go to REQ.
  - A pending-slot entry takes priority over nothing; a fresh strobe in the same cycle goes to the pending slot.
- State REQ:
  - mem_valid = 1; mem_address is stable.
  - On mem_ready = 1, drop mem_valid on the next edge and go to WAIT.
  - mem_rdata_en sampled in the same cycle as mem_ready is accepted: go directly to DONE with the data latched.
- State WAIT:
  - The watchdog counts each cycle.
  - On mem_rdata_en, latch mem_rdata and go to DONE.
  - If the watchdog reaches all-ones first, latch 8'hFF and go to DONE.
  - A late mem_rdata_en arriving after a timeout is ignored.
- State DONE:
  - bus_rdata_en = 1 for exactly one cycle; the watchdog clears.
  - Go to IDLE; if the pending slot is occupied, IDLE launches it on the following cycle.
- Latency: strobe to mem_valid = 1 clk. With zero-wait memory (mem_ready in the first REQ cycle, mem_rdata_en the cycle after), strobe to bus_rdata_en = 4 clks.
- Pending slot:
  - One entry. A strobe while state is not IDLE is stored there.
  - A strobe while the slot is already full overwrites the entry with the newest address and sets overrun.
  - Responses are delivered in strobe order; the newest address wins on overrun.
- busy = (state != IDLE) | pending_valid.
- Address arithmetic: 22-bit add, modulo 2^22, no carry out. Wrap-around past 22'h3FFFFF is legal and not flagged.
- mem_rdata_en outside WAIT/REQ is ignored.
- Reset asserted mid-fetch: everything aborts immediately and mem_valid drops asynchronously. The arbiter must tolerate request withdrawal during reset.

Optional Feature:
- Macro: KANJI_ROM_READER_CACHE_EN.
- Defined:
  - Adds a single-entry cache (last address, last byte, valid bit; valid cleared by reset).
  - A strobe hitting the cached address while IDLE with an empty slot skips REQ/WAIT and goes straight to DONE: bus_rdata_en 2 clks after the strobe, no mem_valid.
  - Timeout responses are not cached.
- Undefined: every strobe issues an external memory read; no cache logic is synthesised.

Test Plan:
- Reset release, strobe 18'h08E40 with BASE_ADDRESS 22'h100000 -> mem_address 22'h108E40 and mem_valid 1 clk later. Memory returns 8'h3C -> bus_rdata 8'h3C, bus_rdata_en a single pulse 4 clks after the strobe.
- Strobe 18'h2D680 (JIS2); memory delays mem_ready 3 clks -> mem_valid held 3 clks with stable address; response 8'hA5 delivered once.
- Three strobes 1 clk apart (A, B, C) with slow memory -> A served; C overwrites B in the slot; overrun = 1; responses arrive in order A then C; busy drops after C.
- mem_ready given but no mem_rdata_en -> bus_rdata 8'hFF after 255 WAIT cycles; a mem_rdata_en injected afterwards produces no extra bus_rdata_en.
- n_reset pulled low while in WAIT -> mem_valid, busy and overrun all 0 and bus_rdata 8'hFF immediately; the next strobe fetches normally.
- With KANJI_ROM_READER_CACHE_EN defined: repeat strobe 18'h08E40 -> no mem_valid, bus_rdata 8'h3C 2 clks after the strobe. With the macro undefined -> a memory read is issued.
